// File: rtl/urisc_pkg.sv
// Shared definitions for the decode stage.
//   - opcode encodings (inst[15:11])
//   - uop control-vector bit indices
//   - dec_t: every field the decode stage presents on its ix_* outputs
//   - decode(): pure combinational decode of one 16-bit instruction word
package urisc_pkg;

    localparam int UOP_BITS = 26;

    localparam logic [4:0] OP_HALT    = 5'b00000;
    localparam logic [4:0] OP_NOP     = 5'b00001;
    localparam logic [4:0] OP_ILLEGAL = 5'b00010;
    localparam logic [4:0] OP_RTI     = 5'b00011;
    localparam logic [4:0] OP_J       = 5'b00100;
    localparam logic [4:0] OP_JR      = 5'b00101;
    localparam logic [4:0] OP_JAL     = 5'b00110;
    localparam logic [4:0] OP_JALR    = 5'b00111;
    localparam logic [4:0] OP_ADDI    = 5'b01000;
    localparam logic [4:0] OP_SUBI    = 5'b01001;
    localparam logic [4:0] OP_XORI    = 5'b01010;
    localparam logic [4:0] OP_ANDNI   = 5'b01011;
    localparam logic [4:0] OP_ST      = 5'b10000;
    localparam logic [4:0] OP_LD      = 5'b10001;
    localparam logic [4:0] OP_SLBI    = 5'b10010;
    localparam logic [4:0] OP_STU     = 5'b10011;
    localparam logic [4:0] OP_LBI     = 5'b11000;
    localparam logic [4:0] OP_BTR     = 5'b11001;
    localparam logic [4:0] OP_RSHIFT  = 5'b11010;
    localparam logic [4:0] OP_RALU    = 5'b11011;

    localparam int UOP_VALID   = 0;
    localparam int UOP_LINK    = 1;
    localparam int UOP_ALUI    = 18;
    localparam int UOP_SLBI    = 19;
    localparam int UOP_SHIFTI  = 20;
    localparam int UOP_LBI     = 21;
    localparam int UOP_BTR     = 22;
    localparam int UOP_RALU    = 23;
    localparam int UOP_RSHIFT  = 24;
    localparam int UOP_CMP     = 25;

    typedef struct packed {
        logic [4:0]          opcode;
        logic [2:0]          rs;
        logic [2:0]          rt;
        logic [2:0]          dest;
        logic                wr_en;
        logic [15:0]         imm;
        logic [UOP_BITS-1:0] uop;
        logic                halt;
        logic                illegal;
        logic                rti;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] inst);
        dec_t d;
        d        = '0;
        d.opcode = inst[15:11];
        d.rs     = inst[10:8];
        d.rt     = inst[7:5];
        // Default immediate is sign-extended inst[7:0]; classes override.
        d.imm    = {{8{inst[7]}}, inst[7:0]};
        d.uop[UOP_VALID] = 1'b1;
        casez (inst[15:11])
            OP_HALT: begin
                d.halt = 1'b1;
                d.uop[UOP_VALID] = 1'b0;
            end
            OP_NOP: d.uop[UOP_VALID] = 1'b0;
            OP_ILLEGAL: begin
                d.illegal = 1'b1;
                d.uop[UOP_VALID] = 1'b0;
            end
            OP_RTI: d.rti = 1'b1;
            5'b001??: begin
                // J/JAL carry an 11-bit displacement; JR/JALR keep the 8-bit default.
                if (!inst[11]) d.imm = {{5{inst[10]}}, inst[10:0]};
                if (inst[12]) begin
                    d.uop[UOP_LINK] = 1'b1;
                    d.dest  = 3'd7;
                    d.wr_en = 1'b1;
                end
            end
            5'b010??: begin
                d.uop[UOP_ALUI] = 1'b1;
                d.dest  = inst[7:5];
                d.wr_en = 1'b1;
                // XORI/ANDNI are logical ops, so their immediate is zero-extended.
                d.imm   = inst[12] ? {11'd0, inst[4:0]} : {{11{inst[4]}}, inst[4:0]};
            end
            5'b011??: ; // branches use the default immediate, no writeback
            OP_ST: d.imm = {{11{inst[4]}}, inst[4:0]};
            OP_LD: begin
                d.imm   = {{11{inst[4]}}, inst[4:0]};
                d.dest  = inst[7:5];
                d.wr_en = 1'b1;
            end
            OP_SLBI: begin
                d.uop[UOP_SLBI] = 1'b1;
                d.imm   = {8'd0, inst[7:0]};
                d.dest  = inst[10:8];
                d.wr_en = 1'b1;
            end
            OP_STU: begin
                d.imm   = {{11{inst[4]}}, inst[4:0]};
                d.dest  = inst[10:8];
                d.wr_en = 1'b1;
            end
            5'b101??: begin
                d.uop[UOP_SHIFTI] = 1'b1;
                d.imm   = {{11{inst[4]}}, inst[4:0]};
                d.dest  = inst[7:5];
                d.wr_en = 1'b1;
            end
            OP_LBI: begin
                d.uop[UOP_LBI] = 1'b1;
                d.dest  = inst[10:8];
                d.wr_en = 1'b1;
            end
            OP_BTR: begin
                d.uop[UOP_BTR] = 1'b1;
                d.dest  = inst[4:2];
                d.wr_en = 1'b1;
            end
            OP_RSHIFT: begin
                d.uop[UOP_RSHIFT] = 1'b1;
                d.dest  = inst[4:2];
                d.wr_en = 1'b1;
            end
            OP_RALU: begin
                d.uop[UOP_RALU] = 1'b1;
                d.dest  = inst[4:2];
                d.wr_en = 1'b1;
            end
            5'b111??: begin
                d.uop[UOP_CMP] = 1'b1;
                d.dest  = inst[4:2];
                d.wr_en = 1'b1;
            end
            default: d.uop[UOP_VALID] = 1'b0; // undefined encodings behave as NOP
        endcase
        return d;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO holding {pc, inst} entries between fetch and decode.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (flush); empties the queue
//   push, din : write an entry (ignored when full)
//   pop       : retire the head entry (ignored when empty)
//   dout      : head entry (valid when !empty)
//   count     : occupancy 0..DEPTH
//   full/empty: status
module inst_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            // full is the pre-edge value: a pop at full does not admit a same-cycle push.
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !rst && !clr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage between fetch and execute.
//   if_*   : fetch side; instruction enters the queue on if_valid & if_ready
//   ix_*   : registered decoded output slot; consumed on ix_valid & ix_ready
//   flush  : discards queue and slot contents, clears halted
//   halted : set when a HALT is loaded into the slot; blocks pushes and pops
//   iq_count: queue occupancy (excludes the output slot)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Producers hold valid and data stable until the transfer; ready may
// toggle freely. A cycle with flush high transfers nothing on either side.
module decode_stage
    import urisc_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int IQ_DEPTH = 4,
    parameter int UOP_W    = UOP_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [15:0]               if_inst,
    input  logic [PC_W-1:0]           if_pc,
    input  logic                      flush,
    input  logic                      ix_ready,
    output logic                      ix_valid,
    output logic [15:0]               ix_inst,
    output logic [PC_W-1:0]           ix_pc,
    output logic [4:0]                ix_opcode,
    output logic [2:0]                ix_rs,
    output logic [2:0]                ix_rt,
    output logic [2:0]                ix_dest,
    output logic                      ix_wr_en,
    output logic [15:0]               ix_imm,
    output logic [UOP_W-1:0]          ix_uop,
    output logic                      ix_halt,
    output logic                      ix_illegal,
    output logic                      ix_rti,
    output logic                      halted,
    output logic [$clog2(IQ_DEPTH):0] iq_count
);
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;
    logic [PC_W+15:0]  q_dout;
    dec_t              dec;

    assign if_ready = !q_full && !halted && !flush && !rst;
    assign push     = if_valid && if_ready;
    // The slot reloads whenever it is empty or being consumed this cycle.
    assign pop      = (!ix_valid || ix_ready) && !q_empty && !halted && !flush;

    inst_queue #(
        .W     (PC_W + 16),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   ({if_pc, if_inst}),
        .dout  (q_dout),
        .count (iq_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign dec = decode(q_dout[15:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ix_valid   <= 1'b0;
            halted     <= 1'b0;
            ix_inst    <= '0;
            ix_pc      <= '0;
            ix_opcode  <= '0;
            ix_rs      <= '0;
            ix_rt      <= '0;
            ix_dest    <= '0;
            ix_wr_en   <= 1'b0;
            ix_imm     <= '0;
            ix_uop     <= '0;
            ix_halt    <= 1'b0;
            ix_illegal <= 1'b0;
            ix_rti     <= 1'b0;
        end else if (flush) begin
            ix_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (pop) begin
            ix_valid   <= 1'b1;
            ix_inst    <= q_dout[15:0];
            ix_pc      <= q_dout[PC_W+15:16];
            ix_opcode  <= dec.opcode;
            ix_rs      <= dec.rs;
            ix_rt      <= dec.rt;
            ix_dest    <= dec.dest;
            ix_wr_en   <= dec.wr_en;
            ix_imm     <= dec.imm;
            ix_uop     <= UOP_W'(dec.uop);
            ix_halt    <= dec.halt;
            ix_illegal <= dec.illegal;
            ix_rti     <= dec.rti;
            // pop implies !halted, so this only ever sets the flag.
            halted     <= dec.halt;
        end else if (ix_ready) begin
            ix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage with a queue-level reference model.
module tb_decode_stage;
    localparam int PC_W     = 16;
    localparam int IQ_DEPTH = 4;
    localparam int UOP_W    = 26;
    localparam int EXP_W    = PC_W + 16 + 3 + 1 + 16 + UOP_W + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_valid = 1'b0;
    logic             if_ready;
    logic [15:0]      if_inst = '0;
    logic [PC_W-1:0]  if_pc = '0;
    logic             flush = 1'b0;
    logic             ix_ready = 1'b0;
    logic             ix_valid;
    logic [15:0]      ix_inst;
    logic [PC_W-1:0]  ix_pc;
    logic [4:0]       ix_opcode;
    logic [2:0]       ix_rs;
    logic [2:0]       ix_rt;
    logic [2:0]       ix_dest;
    logic             ix_wr_en;
    logic [15:0]      ix_imm;
    logic [UOP_W-1:0] ix_uop;
    logic             ix_halt;
    logic             ix_illegal;
    logic             ix_rti;
    logic             halted;
    logic [$clog2(IQ_DEPTH):0] iq_count;

    decode_stage #(.PC_W(PC_W), .IQ_DEPTH(IQ_DEPTH), .UOP_W(UOP_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .ix_ready(ix_ready),
        .ix_valid(ix_valid), .ix_inst(ix_inst), .ix_pc(ix_pc), .ix_opcode(ix_opcode),
        .ix_rs(ix_rs), .ix_rt(ix_rt), .ix_dest(ix_dest), .ix_wr_en(ix_wr_en),
        .ix_imm(ix_imm), .ix_uop(ix_uop), .ix_halt(ix_halt), .ix_illegal(ix_illegal),
        .ix_rti(ix_rti), .halted(halted), .iq_count(iq_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    logic [EXP_W-1:0]     exp_q[$];   // expected decoded stream, oldest first
    logic [PC_W+15:0]     src_q[$];   // fetch-side instructions waiting to be offered
    logic [15:0]          mq[$];      // model of instruction words sitting in the queue
    bit                   m_slot_v = 1'b0;
    bit                   m_halted = 1'b0;
    bit                   m_ready  = 1'b0;
    bit                   mon_en   = 1'b0;
    logic [PC_W-1:0]      next_pc  = '0;
    int                   tests = 0;
    int                   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input int v, input int bits);
        int m;
        int x;
        m = 1 << (bits - 1);
        x = v & ((1 << bits) - 1);
        return 16'((x ^ m) - m);
    endfunction

    // Reference decode written from the opcode-class tables.
    function automatic logic [EXP_W-1:0] ref_expect(input logic [PC_W-1:0] pc, input logic [15:0] inst);
        int op, dest, i5, i8, i11, ra, rb, rc;
        bit wr, h, il, rt;
        logic [15:0] imm;
        logic [UOP_W-1:0] uop;
        op  = int'(inst[15:11]);
        i5  = int'(inst[4:0]);
        i8  = int'(inst[7:0]);
        i11 = int'(inst[10:0]);
        ra  = int'(inst[10:8]);
        rb  = int'(inst[7:5]);
        rc  = int'(inst[4:2]);
        h   = (op == 0);
        il  = (op == 2);
        rt  = (op == 3);
        if (op == 18)                          imm = 16'(i8);
        else if (op == 10 || op == 11)         imm = 16'(i5);
        else if (op == 4 || op == 6)           imm = sext(i11, 11);
        else if (op == 8 || op == 9 || op == 16 || op == 17 || op == 19 || (op >= 20 && op <= 23))
                                               imm = sext(i5, 5);
        else                                   imm = sext(i8, 8);
        if (op == 6 || op == 7)                                       dest = 7;
        else if ((op >= 8 && op <= 11) || (op >= 20 && op <= 23) || op == 17) dest = rb;
        else if (op == 18 || op == 19 || op == 24)                    dest = ra;
        else if (op >= 25)                                            dest = rc;
        else                                                          dest = 0;
        wr = (op == 6 || op == 7 || (op >= 8 && op <= 11) || op == 17 || op == 18 ||
              op == 19 || op >= 20);
        uop     = '0;
        uop[0]  = (op > 2);
        uop[1]  = (op == 6 || op == 7);
        uop[18] = (op >= 8 && op <= 11);
        uop[19] = (op == 18);
        uop[20] = (op >= 20 && op <= 23);
        uop[21] = (op == 24);
        uop[22] = (op == 25);
        uop[23] = (op == 27);
        uop[24] = (op == 26);
        uop[25] = (op >= 28);
        return {pc, inst, 3'(dest), wr, imm, uop, h, il, rt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic add_src(input logic [15:0] inst);
        src_q.push_back({next_pc, inst});
        next_pc = next_pc + 1'b1;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd0 && $urandom_range(0, 7) != 0) op = 5'd1; // keep HALT rare
        return {op, 11'($urandom)};
    endfunction

    // One clock: drive inputs, predict from the model, advance the model after the edge.
    task automatic cycle(input bit v, input bit r, input bit f);
        logic [PC_W+15:0] head;
        logic [15:0]      ld;
        bit do_push, do_load;
        head     = (src_q.size() > 0) ? src_q[0] : '0;
        if_valid = v && (src_q.size() > 0);
        if_inst  = head[15:0];
        if_pc    = head[PC_W+15:16];
        ix_ready = r;
        flush    = f;
        m_ready  = (mq.size() < IQ_DEPTH) && !m_halted && !f;
        do_push  = if_valid && m_ready;
        do_load  = (!m_slot_v || r) && (mq.size() > 0) && !m_halted && !f;
        if (do_push) exp_q.push_back(ref_expect(head[PC_W+15:16], head[15:0]));
        @(posedge clk);
        #1;
        if (f) begin
            mq.delete();
            exp_q.delete();
            m_slot_v = 1'b0;
            m_halted = 1'b0;
        end else begin
            if (do_load) begin
                ld = mq.pop_front();
                m_slot_v = 1'b1;
                if (ld[15:11] == 5'd0) m_halted = 1'b1;
            end else if (r) begin
                m_slot_v = 1'b0;
            end
            if (do_push) begin
                mq.push_back(head[15:0]);
                void'(src_q.pop_front());
            end
        end
    endtask

    task automatic idle_inputs();
        if_valid = 1'b0;
        ix_ready = 1'b0;
        flush    = 1'b0;
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        logic [15:0]      ei;
        if (mon_en) begin
            check("if_ready", 32'(if_ready), 32'(m_ready));
            check("iq_count", 32'(iq_count), 32'(mq.size()));
            check("ix_valid", 32'(ix_valid), 32'(m_slot_v));
            check("halted",   32'(halted),   32'(m_halted));
            if (ix_valid && ix_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(1), 32'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ei = e[64:49];
                    check("ix_pc",      32'(ix_pc),      32'(e[80:65]));
                    check("ix_inst",    32'(ix_inst),    32'(ei));
                    check("ix_opcode",  32'(ix_opcode),  32'(ei[15:11]));
                    check("ix_rs",      32'(ix_rs),      32'(ei[10:8]));
                    check("ix_rt",      32'(ix_rt),      32'(ei[7:5]));
                    check("ix_dest",    32'(ix_dest),    32'(e[48:46]));
                    check("ix_wr_en",   32'(ix_wr_en),   32'(e[45]));
                    check("ix_imm",     32'(ix_imm),     32'(e[44:29]));
                    check("ix_uop",     32'(ix_uop),     32'(e[28:3]));
                    check("ix_halt",    32'(ix_halt),    32'(e[2]));
                    check("ix_illegal", 32'(ix_illegal), 32'(e[1]));
                    check("ix_rti",     32'(ix_rti),     32'(e[0]));
                    // Hand-derived values for a few directed encodings.
                    case (ix_inst)
                        16'h4125: begin
                            check("addi_dest", 32'(ix_dest), 32'd1);
                            check("addi_imm",  32'(ix_imm),  32'h0005);
                            check("addi_uop18", 32'(ix_uop[18]), 32'd1);
                        end
                        16'h23FF: check("j_imm_pos",  32'(ix_imm), 32'h03FF);
                        16'h2400: check("j_imm_neg",  32'(ix_imm), 32'hFC00);
                        16'h27FF: check("j_imm_all1", 32'(ix_imm), 32'hFFFF);
                        16'h91FF: begin
                            check("slbi_imm",  32'(ix_imm),  32'h00FF);
                            check("slbi_dest", 32'(ix_dest), 32'd1);
                        end
                        16'h3000: begin
                            check("jal_dest", 32'(ix_dest),   32'd7);
                            check("jal_link", 32'(ix_uop[1]), 32'd1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ix_valid", 32'(ix_valid), 32'd0);
        check("rst_iq_count", 32'(iq_count), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_halted",   32'(halted),   32'd0);
        check("rst_ix_imm",   32'(ix_imm),   32'd0);
        check("rst_ix_uop",   32'(ix_uop),   32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_if_ready", 32'(if_ready), 32'd1);
        mon_en = 1'b1;

        // Streaming with directed encodings.
        add_src(16'h4125);
        add_src(16'h23FF);
        add_src(16'h2400);
        add_src(16'h27FF);
        add_src(16'h91FF);
        add_src(16'h3000);
        repeat (10) cycle(1'b1, 1'b1, 1'b0);

        // Back-pressure: five instructions, slot plus full queue.
        for (int i = 0; i < 5; i++) add_src(rand_inst() | 16'h0800);
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        idle_inputs();
        check("bp_iq_count", 32'(iq_count), 32'(IQ_DEPTH));
        check("bp_if_ready", 32'(if_ready), 32'd0);
        check("bp_ix_valid", 32'(ix_valid), 32'd1);
        repeat (8) cycle(1'b0, 1'b1, 1'b0);

        // Flush mid-stream: slot valid, three queued, flush with if_valid high.
        for (int i = 0; i < 5; i++) add_src(16'h4000 | 16'(i));
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        idle_inputs();
        check("flush_iq_count", 32'(iq_count), 32'd0);
        check("flush_ix_valid", 32'(ix_valid), 32'd0);
        repeat (6) cycle(1'b1, 1'b1, 1'b0);

        // Halt latching.
        add_src(16'h0000);
        add_src(16'h0800);
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        idle_inputs();
        check("halt_halted",   32'(halted),   32'd1);
        check("halt_if_ready", 32'(if_ready), 32'd0);
        check("halt_iq_count", 32'(iq_count), 32'd1);
        check("halt_ix_halt",  32'(ix_halt),  32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        idle_inputs();
        check("unhalt_halted",   32'(halted),   32'd0);
        check("unhalt_if_ready", 32'(if_ready), 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            bit v, r, f;
            while (src_q.size() < 3) add_src(rand_inst());
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 4) == 0);
            cycle(v, r, f);
        end

        // Drain.
        if (m_halted) cycle(1'b0, 1'b1, 1'b1);
        repeat (IQ_DEPTH + 4) cycle(1'b0, 1'b1, 1'b0);
        idle_inputs();
        mon_en = 1'b0;
        check("drain_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("drain_iq_count",    32'(iq_count),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
